fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_rd_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 67 ++++++
 rtl/fifo_reader.sv | 152 +++++++++++++++
 tb/tb_fifo_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the external-FIFO frame reader.
// Holds the reader FSM state encoding and the default geometry/timeout.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LEN_W_DEF  = 13;
  localparam int unsigned TMO_DEF    = 1023;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the external FIFO and the host port.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push, push_data    write one word at the tail
//   pop                remove the head word
//   flush              discard all stored words (wins over push/pop)
//   head_data          current head word (held while not popped)
//   occupancy          number of stored words, 0..2
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem0_q, mem0_d;
  logic [DATA_W-1:0] mem1_q, mem1_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && (cnt_q != 2'd0)) begin
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // Push lands after the pop has shifted, so a simultaneous push/pop
      // at occupancy 1 refills the head slot.
      if (push && (cnt_d != 2'd2)) begin
        if (cnt_d == 2'd0) begin
          mem0_d = push_data;
        end else begin
          mem1_d = push_data;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = mem0_q;
  assign occupancy = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// Reads a frame of frame_len words from an external synchronous FIFO and
// hands them to the host over a valid/ready port.
// Ports:
//   clk, reset_n          clock (also the FIFO RCLK), async active-low reset
//   data_ready            a frame is stored in the FIFO (level)
//   frame_len             words to read, sampled when the frame starts
//   abort                 one-cycle pulse, cancels the frame in READ/DRAIN
//   FIFO_EF, FIFO_Q       FIFO empty flag (0 = empty) and read data
//   FIFO_REN              FIFO read enable (0 = read), registered
//   rd_data, rd_valid     host word and its qualifier
//   rd_ready              host accepts the word
//   read_over             frame consumed (held until data_ready drops)
//   underrun              frame ended by stall timeout or abort
//   busy                  reader is not idle
module fifo_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned TMO    = TMO_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_ready,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  input  logic              FIFO_EF,
  input  logic [DATA_W-1:0] FIFO_Q,
  output logic              FIFO_REN,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              read_over,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned      ST_W       = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [ST_W-1:0]  STALL_LAST = ST_W'(TMO - 1);

  rd_state_e         state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ST_W-1:0]   stall_q, stall_d;
  logic              ren_q, ren_d;
  logic              under_q, under_d;
  logic              push, pop, flush;
  logic [1:0]        occ;
  logic [2:0]        level;

  // The word strobed out this cycle is captured at the coming edge; a strobe
  // that meets an empty FIFO is ignored by the FIFO, so nothing is captured.
  assign push  = ~ren_q & FIFO_EF;
  assign pop   = rd_valid & rd_ready;
  // Buffer fill right after the coming edge; a new strobe is only safe if
  // its word will still find a free slot with the host stalled.
  assign level = {1'b0, occ} + {2'b00, push} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_d = '0;
    ren_d   = 1'b1;
    under_d = under_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_ready) begin
          rem_d   = frame_len;
          under_d = 1'b0;
          state_d = (frame_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (abort) begin
          flush   = 1'b1;
          under_d = 1'b1;
          rem_d   = '0;
          state_d = DONE;
        end else if ((rem_q != '0) && FIFO_EF) begin
          if (level < 3'd2) begin
            ren_d = 1'b0;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = DRAIN;
            end
          end
        end else if (rem_q != '0) begin
          if (stall_q == STALL_LAST) begin
            under_d = 1'b1;
            rem_d   = '0;
            state_d = DRAIN;
          end else begin
            stall_d = stall_q + ST_W'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          under_d = 1'b1;
          state_d = DONE;
        end else if ((occ == 2'd0) && ren_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!data_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      stall_q <= '0;
      ren_q   <= 1'b1;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      ren_q   <= ren_d;
      under_q <= under_d;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (FIFO_Q),
    .pop       (pop),
    .flush     (flush),
    .head_data (rd_data),
    .occupancy (occ)
  );

  assign FIFO_REN  = ren_q;
  assign rd_valid  = (occ != 2'd0);
  assign read_over = (state_q == DONE);
  assign underrun  = under_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue-based external FIFO model, a word
// scoreboard checked every cycle, and hand-computed per-scenario results.
module tb_fifo_reader;

  localparam int unsigned DW  = 16;
  localparam int unsigned LW  = 13;
  localparam int unsigned TMO = 1023;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          data_ready = 1'b0;
  logic [LW-1:0] frame_len  = '0;
  logic          abort      = 1'b0;
  logic          fifo_ef    = 1'b0;
  logic [DW-1:0] fifo_q     = '0;
  logic          rd_ready   = 1'b0;
  logic          fifo_ren;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          read_over;
  logic          underrun;
  logic          busy;

  fifo_reader #(
    .DATA_W (DW),
    .LEN_W  (LW),
    .TMO    (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_ready (data_ready),
    .frame_len  (frame_len),
    .abort      (abort),
    .FIFO_EF    (fifo_ef),
    .FIFO_Q     (fifo_q),
    .FIFO_REN   (fifo_ren),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .read_over  (read_over),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got[$];

  int cyc         = 0;
  int ren_lows    = 0;
  int delivered   = 0;
  int cur_len     = 0;
  int first_xfer  = -1;
  int last_xfer   = -1;
  int first_empty = -1;
  int under_cyc   = -1;
  int ren_mark    = 0;
  bit ready_toggle = 1'b0;
  bit prev_stall   = 1'b0;
  bit prev_abort   = 1'b0;
  logic [DW-1:0] prev_data = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void drive_fifo();
    fifo_ef = (fifo_mem.size() != 0);
    fifo_q  = fifo_ef ? fifo_mem[0] : '0;
  endfunction

  // One clock: sample just after the low phase starts, check, then advance
  // the FIFO model and scoreboard just after the rising edge.
  task automatic cycle();
    bit hs, rlow, ab;
    logic [DW-1:0] w;
    #2;
    hs   = rd_valid && rd_ready;
    rlow = !fifo_ren;
    ab   = abort;
    if (prev_stall && !prev_abort) begin
      check("hold_valid", rd_valid, 1);
      check("hold_data", rd_data, prev_data);
    end
    if (hs) begin
      check("word_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_order", rd_data, w);
      end
      got.push_back(rd_data);
      delivered++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    if (rlow) begin
      ren_lows++;
      check("ren_within_len", ren_lows <= cur_len, 1);
    end
    if (busy && !fifo_ef && first_empty < 0) first_empty = cyc;
    if (busy && underrun && under_cyc < 0) under_cyc = cyc;
    prev_stall = rd_valid && !rd_ready;
    prev_data  = rd_data;
    prev_abort = ab;
    @(posedge clk);
    #1;
    if (rlow && fifo_mem.size() != 0) begin
      w = fifo_mem.pop_front();
      if (!ab) exp_q.push_back(w);
    end
    if (ab) exp_q.delete();
    check("occupancy_le2", exp_q.size() <= 2, 1);
    drive_fifo();
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    if (ready_toggle) rd_ready = ~rd_ready;
    cycle();
  endtask

  task automatic start_frame(int len, int nwords, logic [DW-1:0] base);
    fifo_mem.delete();
    for (int i = 0; i < nwords; i++) fifo_mem.push_back(base + DW'(i));
    drive_fifo();
    exp_q.delete();
    got.delete();
    ren_lows    = 0;
    delivered   = 0;
    cur_len     = len;
    first_xfer  = -1;
    last_xfer   = -1;
    first_empty = -1;
    under_cyc   = -1;
    frame_len   = LW'(len);
    data_ready  = 1'b1;
  endtask

  task automatic wait_done(int limit);
    int n = 0;
    while (!read_over && n < limit) begin
      step();
      n++;
    end
    check("done_reached", read_over, 1);
  endtask

  task automatic wait_words(int k, int limit);
    int n = 0;
    while (delivered < k && n < limit) begin
      step();
      n++;
    end
    check("words_reached", delivered >= k, 1);
  endtask

  task automatic end_frame();
    data_ready = 1'b0;
    step();
    check("idle_busy", busy, 0);
    check("idle_read_over", read_over, 0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_ren"}, fifo_ren, 1);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_read_over"}, read_over, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, rd_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    drive_fifo();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Basic frame: 4 words streamed back to back.
    rd_ready = 1'b1;
    ready_toggle = 1'b0;
    start_frame(4, 4, 16'h0001);
    wait_done(50);
    check("s1_count", delivered, 4);
    check("s1_first", got[0], 16'h0001);
    check("s1_last", got[3], 16'h0004);
    check("s1_ren_cycles", ren_lows, 4);
    check("s1_burst", last_xfer - first_xfer, 3);
    check("s1_underrun", underrun, 0);
    check("s1_busy", busy, 1);
    end_frame();

    // Backpressure, with data_ready dropped mid-frame.
    ready_toggle = 1'b1;
    rd_ready = 1'b1;
    start_frame(8, 8, 16'h0100);
    repeat (3) step();
    data_ready = 1'b0;
    wait_done(100);
    check("s2_count", delivered, 8);
    check("s2_last", got[7], 16'h0107);
    check("s2_ren_cycles", ren_lows, 8);
    check("s2_underrun", underrun, 0);
    step();
    check("s2_idle", busy, 0);
    ready_toggle = 1'b0;
    rd_ready = 1'b1;

    // Empty stall: FIFO runs dry, timeout ends the frame.
    start_frame(6, 3, 16'h0200);
    wait_done(1200);
    check("s3_count", delivered, 3);
    check("s3_last", got[2], 16'h0202);
    check("s3_underrun", underrun, 1);
    check("s3_timeout", under_cyc - first_empty, TMO);
    end_frame();

    // Abort after 10 words.
    start_frame(100, 100, 16'h1000);
    wait_words(10, 100);
    check("s4_tenth", got[9], 16'h1009);
    abort = 1'b1;
    step();
    abort = 1'b0;
    ren_mark = ren_lows;
    check("s4_ren_high", fifo_ren, 1);
    check("s4_valid_low", rd_valid, 0);
    check("s4_read_over", read_over, 1);
    check("s4_underrun", underrun, 1);
    repeat (3) step();
    check("s4_no_more_reads", ren_lows, ren_mark);
    check("s4_held_done", read_over, 1);
    end_frame();

    // Zero length.
    start_frame(0, 2, 16'h3000);
    repeat (3) step();
    check("s5_read_over", read_over, 1);
    check("s5_no_reads", ren_lows, 0);
    check("s5_fifo_untouched", fifo_mem.size(), 2);
    check("s5_underrun", underrun, 0);
    end_frame();

    // Reset in the middle of a frame, then a clean 4-word frame.
    start_frame(20, 20, 16'h4000);
    wait_words(5, 100);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    data_ready = 1'b0;
    exp_q.delete();
    fifo_mem.delete();
    drive_fifo();
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("held_reset");
    reset_n = 1'b1;
    start_frame(4, 4, 16'h0A01);
    wait_done(50);
    check("s6_count", delivered, 4);
    check("s6_first", got[0], 16'h0A01);
    check("s6_last", got[3], 16'h0A04);
    check("s6_underrun", underrun, 0);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
